// File: rtl/obj_sched_pkg.sv
// Shared definitions for the object update scheduler: command opcodes, FSM
// state codes and the queued command record.
package obj_sched_pkg;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_SETXY = 2'd1;
    localparam logic [1:0] OP_PIXEL = 2'd2;
    localparam logic [1:0] OP_FENCE = 2'd3;

    // Fixed-width id field so the record type does not depend on N_OBJ
    localparam int unsigned CMD_ID_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_FWAIT  = 3'd4;

    typedef struct packed {
        logic [1:0]          op;
        logic [CMD_ID_W-1:0] id;
        logic [9:0]          x;
        logic [9:0]          y;
        logic [23:0]         data;
    } obj_cmd_t;

    function automatic logic is_update(input logic [1:0] op);
        return (op == OP_SETXY) || (op == OP_PIXEL);
    endfunction

endpackage

// File: rtl/obj_update_scheduler_if.sv
// Host command handshake into the object update scheduler.
interface obj_update_scheduler_if #(
    parameter int unsigned N_OBJ = 8
);
    localparam int unsigned IDW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [IDW-1:0] cmd_id;
    logic [9:0]     cmd_x;
    logic [9:0]     cmd_y;
    logic [23:0]    cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_id, cmd_x, cmd_y, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_id, cmd_x, cmd_y, cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/obj_cmd_fifo.sv
// Single-clock show-ahead FIFO of command records; simultaneous write and
// read is accepted when full.
module obj_cmd_fifo
    import obj_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr,
    input  obj_cmd_t               i_wdata,
    input  logic                   i_rd,
    output obj_cmd_t               o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    obj_cmd_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_do_wr;
    logic            w_do_rd;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/obj_update_scheduler.sv
// Queues host object-update commands and applies them to the object bank only
// during vertical blanking; owns the shared object x/y query bus.
module obj_update_scheduler
    import obj_sched_pkg::*;
#(
    parameter int unsigned N_OBJ      = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_TOTAL    = 525,
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    obj_update_scheduler_if.slave cmd_if,
    input  logic [9:0]            scan_x,
    input  logic [9:0]            scan_y,
    output logic [N_OBJ-1:0]      obj_sel,
    output logic [9:0]            obj_new_x,
    output logic [9:0]            obj_new_y,
    output logic [23:0]           obj_in,
    output logic [9:0]            obj_x,
    output logic [9:0]            obj_y,
    output logic                  obj_setxy,
    output logic                  obj_change_pxl,
    output logic                  busy,
    output logic [CW-1:0]         fifo_count,
    output logic [15:0]           frame_cnt
);
    obj_cmd_t         w_wdata;
    obj_cmd_t         w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_pop;
    logic             w_vblank;
    logic             w_last_line;
    logic             w_vb_start;
    logic             w_drive;
    logic [N_OBJ-1:0] w_sel;

    logic [2:0]       r_state;
    obj_cmd_t         r_cmd;
    logic             r_vb;
    logic             r_vb_d;
    logic [15:0]      r_frame;
    logic [N_OBJ-1:0] r_sel;
    logic [9:0]       r_new_x;
    logic [9:0]       r_new_y;
    logic [23:0]      r_in;
    logic             r_setxy;
    logic             r_pxl;
    logic [9:0]       r_obj_x;
    logic [9:0]       r_obj_y;

    assign w_wdata.op   = cmd_if.cmd_op;
    assign w_wdata.id   = CMD_ID_W'(cmd_if.cmd_id);
    assign w_wdata.x    = cmd_if.cmd_x;
    assign w_wdata.y    = cmd_if.cmd_y;
    assign w_wdata.data = cmd_if.cmd_data;

    assign cmd_if.cmd_ready = !w_full;
    assign w_wr             = cmd_if.cmd_valid && !w_full;

    assign w_vblank    = (scan_y >= 10'(V_ACTIVE));
    assign w_last_line = (scan_y == 10'(V_TOTAL - 1));
    assign w_vb_start  = r_vb && !r_vb_d;
    // Never start a command in the last blanking line so it cannot spill into active video
    assign w_pop       = (r_state == ST_IDLE) && !w_empty && w_vblank && !w_last_line;
    assign w_drive     = (r_state == ST_DECODE) && is_update(r_cmd.op);

    obj_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr),
        .i_wdata (w_wdata),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Out-of-range ids decode to an all-zero select
    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            if (r_cmd.id == CMD_ID_W'(i)) begin
                w_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vb    <= 1'b0;
            r_vb_d  <= 1'b0;
            r_frame <= '0;
        end else begin
            r_vb   <= w_vblank;
            r_vb_d <= r_vb;
            if (w_vb_start) begin
                r_frame <= r_frame + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_sel   <= '0;
            r_new_x <= '0;
            r_new_y <= '0;
            r_in    <= '0;
            r_setxy <= 1'b0;
            r_pxl   <= 1'b0;
        end else begin
            r_setxy <= 1'b0;
            r_pxl   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cmd   <= w_head;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (r_cmd.op)
                        OP_SETXY: begin
                            r_sel   <= w_sel;
                            r_new_x <= r_cmd.x;
                            r_new_y <= r_cmd.y;
                            r_setxy <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                        OP_PIXEL: begin
                            r_sel   <= w_sel;
                            r_in    <= r_cmd.data;
                            r_pxl   <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                        OP_FENCE: r_state <= ST_FWAIT;
                        default:  r_state <= ST_IDLE;
                    endcase
                end
                ST_ISSUE: begin
                    r_sel   <= '0;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: r_state <= ST_IDLE;
                ST_FWAIT: begin
                    if (w_vb_start) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Unreset on purpose: the bus simply tracks the raster while idle or in reset
    always_ff @(posedge clk) begin
        r_obj_x <= w_drive ? r_cmd.x : scan_x;
        r_obj_y <= w_drive ? r_cmd.y : scan_y;
    end

    assign obj_sel        = r_sel;
    assign obj_new_x      = r_new_x;
    assign obj_new_y      = r_new_y;
    assign obj_in         = r_in;
    assign obj_x          = r_obj_x;
    assign obj_y          = r_obj_y;
    assign obj_setxy      = r_setxy;
    assign obj_change_pxl = r_pxl;
    assign busy           = (r_state != ST_IDLE) || !w_empty;
    assign frame_cnt      = r_frame;

endmodule
